fetch_pc_gen: RTL
=================

// Module: fetch_pc_gen
// PURPOSE
//  Multi-slot successor of the frontend PC generator. Issues one aligned fetch block of FETCH_WIDTH
//  32-bit slots per valid/ready handshake to the instruction fetch unit. Priority for next PC:
//  backend flush, then same-cycle branch prediction, then sequential. Adds an epoch tag for stale-fetch
//  discard, a slot-valid mask, and a halt/resume FSM. Sits between the branch predictor and fetch.
// PARAMETERS
//  ADDR_WIDTH   32  PC width; all PC arithmetic is modulo 2^ADDR_WIDTH
//  FETCH_WIDTH  4   slots per fetch block; power of two, 1..8
//  EPOCH_WIDTH  3   epoch tag width
// PORTS
//  CLK           in   1            clock
//  RSTN          in   1            asynchronous active-low reset
//  BOOT_ADDR     in   ADDR_WIDTH   reset PC; held stable while RSTN low and one cycle after
//  pc_valid      out  1            fetch request valid
//  pc_ready      in   1            fetch unit accepts request
//  pc_out        out  ADDR_WIDTH   request PC (bits[1:0]=0)
//  pc_mask       out  FETCH_WIDTH  bit i: slot i of this block is to be executed
//  pc_taken      out  1            block ends on a predicted-taken slot
//  pc_epoch      out  EPOCH_WIDTH  epoch of this request
//  bp_taken      in   1            predictor, combinational on pc_out: taken in this block
//  bp_slot       in   log2(FW)     slot index of the taken branch (0 when FETCH_WIDTH=1)
//  bp_target     in   ADDR_WIDTH   predicted target
//  flush_valid   in   1            backend redirect
//  flush_target  in   ADDR_WIDTH   redirect PC
//  halt_req      in   1            level request to stop issuing (debug/WFI)
// BEHAVIOUR
//  FETCH_BYTES = 4*FETCH_WIDTH; off = pc_reg[log2(FETCH_BYTES)-1:2]; hs = pc_valid & pc_ready.
//  Reset: state=BOOT, pc_reg=BOOT_ADDR&~3, epoch=0. Outputs: pc_valid=0, pc_taken=0, pc_mask=0,
//   pc_out=pc_reg, pc_epoch=0.
//  FSM states BOOT, RUN, HALT; pc_valid = (state==RUN).
//   BOOT->RUN after one cycle (HALT instead if halt_req=1).
//   RUN->HALT on hs & halt_req; RUN holds otherwise.
//   HALT->RUN when halt_req=0.
//  Outputs in RUN are combinational on pc_reg and bp_*:
//   eff_taken = bp_taken & (bp_slot >= off); a taken slot below off is ignored.
//   pc_mask[i] = (i >= off) & (~eff_taken | i <= bp_slot); pc_taken = eff_taken.
//   Masks are zero outside RUN.
//  Next PC, registered, in priority order:
//   1 flush_valid in any state: pc_reg <= flush_target&~3; epoch <= epoch+1, wrapping 2^EPOCH_WIDTH-1 -> 0.
//     Flush wins over hs. A block handshaked in the flush cycle carries the old epoch.
//     FSM: BOOT->RUN, RUN stays RUN; HALT stays HALT unless halt_req=0.
//   2 hs & eff_taken: pc_reg <= bp_target&~3.
//   3 hs: pc_reg <= (pc_reg & ~(FETCH_BYTES-1)) + FETCH_BYTES, wrapping to 0 at top of address space.
//   4 else: hold.
//  Valid/ready rule: while pc_valid=1 and no hs, pc_out/pc_epoch stay stable; the only exception is a flush.
//   pc_valid never drops without hs; halt takes effect only after hs.
//  Latency: flush to new pc_out is 1 cycle; hs to next pc_out is 1 cycle. No bubbles in steady state.
//  Reset asserted mid-operation returns all state to reset values immediately; pending requests are lost.
// STRUCTURE
//  Shared frontend package: FSM state encodings; FETCH_BYTES/slot-offset localparams;
//   pc_align(pc, bytes) function.
//  One sub-module: fetch_slot_mask, combinational (off, bp_taken, bp_slot -> pc_mask, eff_taken).
//  Top holds the FSM, pc_reg, epoch and next-PC mux.
// TESTING (FETCH_WIDTH=4, ADDR_WIDTH=32, EPOCH_WIDTH=3)
//  1 BOOT_ADDR=0x1000, ready=1 -> cycle 1 after reset: valid=0; then 0x1000/1111, 0x1010/1111, 0x1020.
//  2 BOOT_ADDR=0x1008 -> first block 0x1008 mask 1100; next 0x1010 mask 1111.
//  3 ready=0 for 3 cycles at 0x1010 -> pc_out, mask, epoch stable; after ready=1 next is 0x1020.
//  4 at 0x1000, bp_taken slot1 target 0x2004 -> mask 0011, taken=1; next 0x2004 mask 1110;
//    at 0x1008, bp slot0 -> ignored, mask 1100.
//  5 flush 0x3000 in the same cycle as hs+bp_taken -> next pc 0x3000, epoch 0->1;
//    eighth flush wraps epoch 7->0; flush in BOOT -> 0x3000 issued.
//  6 halt_req=1 with ready=0 -> valid held until hs, then 0; flush 0x4000 while halted;
//    halt_req=0 -> 0x4000 issued. pc 0xFFFFFFF0 + hs -> 0x00000000.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared frontend definitions: PC generator FSM encoding, fetch-block geometry helpers
// and PC alignment.
package fetch_pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam int unsigned SLOT_BYTES      = 4;
   localparam int unsigned DEF_FETCH_WIDTH = 4;
   localparam int unsigned DEF_FETCH_BYTES = SLOT_BYTES * DEF_FETCH_WIDTH;
   localparam int unsigned DEF_SLOT_W      = $clog2(DEF_FETCH_WIDTH);

   function automatic int unsigned fetch_bytes(input int unsigned fetch_width);
      return SLOT_BYTES * fetch_width;
   endfunction

   // Slot index width; a single-slot block still carries a 1-bit (always zero) index.
   function automatic int unsigned slot_idx_w(input int unsigned fetch_width);
      return (fetch_width > 1) ? $clog2(fetch_width) : 1;
   endfunction

   // Clears the low bits of pc so it sits on a 'bytes' boundary (bytes is a power of two).
   function automatic logic [63:0] pc_align(input logic [63:0] pc, input logic [63:0] bytes);
      return pc & ~(bytes - 64'd1);
   endfunction

endpackage

// File: rtl/fetch_slot_mask.sv
// Slot-valid mask for one fetch block: slots before the entry offset and after a
// predicted-taken slot are masked off.
module fetch_slot_mask
   import fetch_pc_gen_pkg::*;
#(
   parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
   parameter int unsigned SLOT_W      = slot_idx_w(DEF_FETCH_WIDTH)
) (
   input  logic [SLOT_W-1:0]      off,
   input  logic                   bp_taken,
   input  logic [SLOT_W-1:0]      bp_slot,
   output logic [FETCH_WIDTH-1:0] slot_mask,
   output logic                   eff_taken
);

   always_comb begin
      // A taken branch in a slot we entered past cannot redirect this block.
      eff_taken = bp_taken & (bp_slot >= off);
      slot_mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         slot_mask[i] = (SLOT_W'(i) >= off) & (~eff_taken | (SLOT_W'(i) <= bp_slot));
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Frontend PC generator: issues aligned multi-slot fetch blocks with flush/prediction/
// sequential next-PC selection, an epoch tag and a halt/resume FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_BOOT | one cycle after reset, pc_reg holds the boot PC, no request
//   ST_RUN  | request presented on pc_valid, advancing on each handshake
//   ST_HALT | issuing stopped while halt_req is high; flushes still land
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
   parameter int unsigned EPOCH_WIDTH = 3,
   localparam int unsigned SLOT_W     = slot_idx_w(FETCH_WIDTH)
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic [ADDR_WIDTH-1:0]  BOOT_ADDR,
   output logic                   pc_valid,
   input  logic                   pc_ready,
   output logic [ADDR_WIDTH-1:0]  pc_out,
   output logic [FETCH_WIDTH-1:0] pc_mask,
   output logic                   pc_taken,
   output logic [EPOCH_WIDTH-1:0] pc_epoch,
   input  logic                   bp_taken,
   input  logic [SLOT_W-1:0]      bp_slot,
   input  logic [ADDR_WIDTH-1:0]  bp_target,
   input  logic                   flush_valid,
   input  logic [ADDR_WIDTH-1:0]  flush_target,
   input  logic                   halt_req
);

   localparam int unsigned FETCH_BYTES = fetch_bytes(FETCH_WIDTH);
   localparam int unsigned BLK_LSB     = $clog2(FETCH_BYTES);

   fetch_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;

   logic [SLOT_W-1:0]      off;
   logic [FETCH_WIDTH-1:0] raw_mask;
   logic                   raw_taken;
   logic                   hs;
   logic [ADDR_WIDTH-1:0]  boot_al;
   logic [ADDR_WIDTH-1:0]  flush_al;
   logic [ADDR_WIDTH-1:0]  target_al;
   logic [ADDR_WIDTH-1:0]  pc_seq;

   generate
      if (FETCH_WIDTH > 1) begin : g_off
         assign off = pc_q[BLK_LSB-1:2];
      end else begin : g_off_single
         assign off = '0;
      end
   endgenerate

   fetch_slot_mask #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .SLOT_W      (SLOT_W)
   ) u_slot_mask (
      .off       (off),
      .bp_taken  (bp_taken),
      .bp_slot   (bp_slot),
      .slot_mask (raw_mask),
      .eff_taken (raw_taken)
   );

   assign pc_valid = (state_q == ST_RUN);
   assign pc_mask  = pc_valid ? raw_mask : '0;
   assign pc_taken = pc_valid & raw_taken;
   assign pc_out   = pc_q;
   assign pc_epoch = epoch_q;
   assign hs       = pc_valid & pc_ready;

   assign boot_al   = ADDR_WIDTH'(pc_align(64'(BOOT_ADDR), 64'(SLOT_BYTES)));
   assign flush_al  = ADDR_WIDTH'(pc_align(64'(flush_target), 64'(SLOT_BYTES)));
   assign target_al = ADDR_WIDTH'(pc_align(64'(bp_target), 64'(SLOT_BYTES)));
   // Sequential successor is the next block boundary; the add wraps at the top of memory.
   assign pc_seq    = ADDR_WIDTH'(pc_align(64'(pc_q), 64'(FETCH_BYTES)))
                    + ADDR_WIDTH'(FETCH_BYTES);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epoch_d = epoch_q;

      unique case (state_q)
         ST_BOOT: state_d = halt_req ? ST_HALT : ST_RUN;
         ST_RUN:  if (hs && halt_req) state_d = ST_HALT;
         ST_HALT: if (!halt_req) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase

      if (flush_valid) begin
         pc_d    = flush_al;
         epoch_d = epoch_q + EPOCH_WIDTH'(1);
         // A flush restarts issue: it never parks a running or booting generator.
         if (state_q == ST_BOOT || state_q == ST_RUN) begin
            state_d = ST_RUN;
         end
      end else if (hs && raw_taken) begin
         pc_d = target_al;
      end else if (hs) begin
         pc_d = pc_seq;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_BOOT;
         pc_q    <= boot_al;
         epoch_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epoch_q <= epoch_d;
      end
   end

endmodule
